// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM stage: state encoding, pipeline
// field widths and the poison value returned by a timed-out load.
package mem_stage_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a data-memory request has gone unacknowledged and flags the
// final allowed cycle so the controller can abort the access.
module mem_wait_timer
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic access_i,
  input  logic req_i,
  input  logic ack_i,
  output logic tout_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tout_o = req_i & ~ack_i & (cnt_q == CNT_LAST);

  // Clearing on tout keeps the count inside 0..TIMEOUT-1 so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (~access_i | (req_i & ack_i) | tout_o) begin
      cnt_d = '0;
    end else if (req_i & ~ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the pipelined CPU: req/ack data-memory handshake with timeout,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [REG_W-1:0]  mrd,
  input  logic [DATA_W-1:0] mr,
  input  logic [DATA_W-1:0] mqb,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [REG_W-1:0]  wrd,
  output logic [DATA_W-1:0] wr,
  output logic [DATA_W-1:0] wmo
);

  mem_state_e state_q, state_d;

  logic access;
  logic done;
  logic tout;

  logic              wwreg_q, wwreg_d;
  logic              wm2reg_q, wm2reg_d;
  logic [REG_W-1:0]  wrd_q, wrd_d;
  logic [DATA_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] wmo_q, wmo_d;
  logic              err_q;

  assign access     = mm2reg | mwmem;
  assign dmem_req   = access & (state_q != ABORT);
  assign dmem_we    = mwmem;
  assign dmem_addr  = mr;
  assign dmem_wdata = mqb;
  assign done       = dmem_req & dmem_ack;
  assign mem_stall  = access & ~done & ~tout;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .access_i (access),
    .req_i    (dmem_req),
    .ack_i    (dmem_ack),
    .tout_o   (tout)
  );

  // ABORT lasts one cycle with the request dropped, which swallows any late ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tout) begin
          state_d = ABORT;
        end else if (dmem_req & ~dmem_ack) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done | ~dmem_req) begin
          state_d = IDLE;
        end else if (tout) begin
          state_d = ABORT;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // While stalled a bubble goes to WB; a timed-out access retires without a write.
  always_comb begin
    wwreg_d  = 1'b0;
    wm2reg_d = 1'b0;
    wrd_d    = wrd_q;
    wr_d     = wr_q;
    wmo_d    = wmo_q;
    if (!mem_stall) begin
      wwreg_d  = mwreg & ~tout;
      wm2reg_d = mm2reg & ~tout;
      wrd_d    = mrd;
      wr_d     = mr;
      if (done & ~mwmem) begin
        wmo_d = dmem_rdata;
      end else if (tout & mm2reg) begin
        wmo_d = ERR_DATA;
      end else begin
        wmo_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wrd_q    <= '0;
      wr_q     <= '0;
      wmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wrd_q    <= wrd_d;
      wr_q     <= wr_d;
      wmo_q    <= wmo_d;
      err_q    <= tout;
    end
  end

  assign wwreg   = wwreg_q;
  assign wm2reg  = wm2reg_q;
  assign wrd     = wrd_q;
  assign wr      = wr_q;
  assign wmo     = wmo_q;
  assign mem_err = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: per-cycle vectors check the bus and
// stall outputs, and a queue of retiring instructions checks the MEM/WB register.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwreg, mm2reg, mwmem, dmem_ack;
  logic [4:0]  mrd;
  logic [31:0] mr, mqb, dmem_rdata;
  logic        dmem_req, dmem_we, mem_stall, mem_err, wwreg, wm2reg;
  logic [31:0] dmem_addr, dmem_wdata, wr, wmo;
  logic [4:0]  wrd;

  typedef struct {
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mrd;
    logic [31:0] mr, mqb;
    logic        ack;
    logic [31:0] rdata;
    logic        eReq, eWe, eStall, eWwreg, eWm2reg;
    logic [31:0] eWmo;
    logic        eErr;
  } vec_t;

  typedef struct packed {
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrd;
    logic [31:0] wr;
    logic [31:0] wmo;
  } wb_t;

  wb_t  sbQ[$];
  wb_t  lastWb;
  vec_t tbl[$];
  int   compared   = 0;
  int   mismatched = 0;

  mem_stage_ctrl #(
    .TIMEOUT  (16),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .mrd        (mrd),
    .mr         (mr),
    .mqb        (mqb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wrd        (wrd),
    .wr         (wr),
    .wmo        (wmo)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(int iWreg, int iM2reg, int iWmem, int iRd,
                              logic [31:0] iR, logic [31:0] iQb, int iAck,
                              logic [31:0] iRdata, int xReq, int xWe, int xStall,
                              int xWwreg, int xWm2reg, logic [31:0] xWmo, int xErr);
    vec_t v;
    v.mwreg   = 1'(iWreg);
    v.mm2reg  = 1'(iM2reg);
    v.mwmem   = 1'(iWmem);
    v.mrd     = 5'(iRd);
    v.mr      = iR;
    v.mqb     = iQb;
    v.ack     = 1'(iAck);
    v.rdata   = iRdata;
    v.eReq    = 1'(xReq);
    v.eWe     = 1'(xWe);
    v.eStall  = 1'(xStall);
    v.eWwreg  = 1'(xWwreg);
    v.eWm2reg = 1'(xWm2reg);
    v.eWmo    = xWmo;
    v.eErr    = 1'(xErr);
    return v;
  endfunction

  task automatic check(input string nm, input int tag, input logic [31:0] got,
                       input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s #%0d: got %h, expected %h", nm, tag, got, want);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    mwreg      = v.mwreg;
    mm2reg     = v.mm2reg;
    mwmem      = v.mwmem;
    mrd        = v.mrd;
    mr         = v.mr;
    mqb        = v.mqb;
    dmem_ack   = v.ack;
    dmem_rdata = v.rdata;
  endtask

  // Called just after a rising edge: compares the retiring record (or a bubble).
  task automatic checkOutput(input logic eErr, input int tag);
    wb_t exp;
    if (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
    end else begin
      exp        = lastWb;
      exp.wwreg  = 1'b0;
      exp.wm2reg = 1'b0;
    end
    lastWb = exp;
    check("wwreg",   tag, 32'(wwreg),  32'(exp.wwreg));
    check("wm2reg",  tag, 32'(wm2reg), 32'(exp.wm2reg));
    check("wrd",     tag, 32'(wrd),    32'(exp.wrd));
    check("wr",      tag, wr,          exp.wr);
    check("wmo",     tag, wmo,         exp.wmo);
    check("mem_err", tag, 32'(mem_err), 32'(eErr));
  endtask

  // One pipeline cycle: entered and left just after a rising edge.
  task automatic applyStimulus(input vec_t v, input int tag);
    driveInputs(v);
    @(negedge clock);
    check("dmem_req",   tag, 32'(dmem_req),  32'(v.eReq));
    check("dmem_we",    tag, 32'(dmem_we),   32'(v.eWe));
    check("dmem_addr",  tag, dmem_addr,      v.mr);
    check("dmem_wdata", tag, dmem_wdata,     v.mqb);
    check("mem_stall",  tag, 32'(mem_stall), 32'(v.eStall));
    if (!v.eStall) begin
      sbQ.push_back('{v.eWwreg, v.eWm2reg, v.mrd, v.mr, v.eWmo});
    end
    @(posedge clock);
    #1;
    checkOutput(v.eErr, tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    lastWb = '0;
    driveInputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check("rst_wwreg",   0, 32'(wwreg),     0);
    check("rst_wm2reg",  0, 32'(wm2reg),    0);
    check("rst_wrd",     0, 32'(wrd),       0);
    check("rst_wr",      0, wr,             0);
    check("rst_wmo",     0, wmo,            0);
    check("rst_mem_err", 0, 32'(mem_err),   0);
    check("rst_req",     0, 32'(dmem_req),  0);
    check("rst_stall",   0, 32'(mem_stall), 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // ALU op, zero-wait load, store acked after three wait cycles, load+store, one-wait load
    tbl.push_back(mk(1, 0, 0, 5, 32'h10, 32'h0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 0, 3, 32'h100, 32'h0, 1, 32'hCAFEF00D, 1, 0, 0, 1, 1, 32'hCAFEF00D, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 1, 7, 32'h200, 32'h1234, 0, 32'h0, 1, 1, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 32'h200, 32'h1234, 1, 32'h5A5A, 1, 1, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 1, 8, 32'h240, 32'h4321, 1, 32'h1111, 1, 1, 0, 1, 1, 32'h0, 0));
    tbl.push_back(mk(1, 1, 0, 4, 32'h280, 32'h0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 0, 4, 32'h280, 32'h0, 1, 32'h55AA, 1, 0, 0, 1, 1, 32'h55AA, 0));
    tbl.push_back(mk(1, 0, 0, 6, 32'h2C0, 32'h0, 1, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0));
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i + 1);

    // Load that never gets an ack: 15 stalled cycles, then the timeout cycle
    for (int i = 0; i < 15; i++)
      applyStimulus(mk(1, 1, 0, 9, 32'h300, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 100 + i);
    applyStimulus(mk(1, 1, 0, 9, 32'h300, 0, 0, 0, 1, 0, 0, 0, 0, ERR_DATA, 1), 115);
    // ABORT cycle with a late ack and the next load already waiting
    applyStimulus(mk(1, 1, 0, 10, 32'h400, 0, 1, 32'h9999, 0, 0, 1, 0, 0, 0, 0), 200);
    applyStimulus(mk(1, 1, 0, 10, 32'h400, 0, 1, 32'h77, 1, 0, 0, 1, 1, 32'h77, 0), 201);

    // Reset asserted in the second cycle of a waiting load
    applyStimulus(mk(1, 1, 0, 12, 32'h500, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 300);
    driveInputs(mk(1, 1, 0, 12, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("arst_wwreg",   301, 32'(wwreg),   0);
    check("arst_wm2reg",  301, 32'(wm2reg),  0);
    check("arst_wrd",     301, 32'(wrd),     0);
    check("arst_wr",      301, wr,           0);
    check("arst_wmo",     301, wmo,          0);
    check("arst_mem_err", 301, 32'(mem_err), 0);
    check("arst_state",   301, 32'(dut.state_q), 32'(IDLE));
    check("arst_cnt",     301, 32'(dut.u_timer.cnt_q), 0);
    driveInputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("arst_req",   302, 32'(dmem_req),  0);
    check("arst_stall", 302, 32'(mem_stall), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    sbQ.delete();
    lastWb = '0;
    applyStimulus(mk(1, 1, 0, 13, 32'h600, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 310);
    applyStimulus(mk(1, 1, 0, 13, 32'h600, 0, 1, 32'hABCD, 1, 0, 0, 1, 1, 32'hABCD, 0), 311);
    applyStimulus(mk(1, 0, 0, 14, 32'h700, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 312);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
